// File: rtl/pattern_fetch.sv
// Pattern-word fetcher: reads one background word and up to NUM_SPRITES sprite words
// during horizontal blank, buffers them, and hands them to the shift registers on commit.
module pattern_fetch #(
  parameter int NUM_SPRITES = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              commit,
  input  logic [3:0]        sprite_count,
  input  logic [ADDR_W-1:0] sprite_addr [NUM_SPRITES-1:0],
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] load_data [NUM_SPRITES:0],
  output logic              load_sprite,
  output logic              load_background,
  output logic              busy,
  output logic              ready,
  output logic              overrun
);

  localparam logic [3:0] MAX_CNT = 4'(NUM_SPRITES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, READY} state_t;

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [3:0]        idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic              load_q, load_d;
  logic              take_start;
  logic              capture;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] bg_addr_q;
  logic [ADDR_W-1:0] spr_addr_q [NUM_SPRITES-1:0];
  logic [DATA_W-1:0] buf_q [NUM_SPRITES:0];

  // Fetch index 0 is the background; index k>0 is sprite slot k-1.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    overrun_d  = overrun_q;
    load_d     = 1'b0;
    take_start = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit) overrun_d = 1'b1;
        if (start) begin
          take_start = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (start || commit) overrun_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (start || commit) overrun_d = 1'b1;
        if (mem_rvalid) begin
          capture = 1'b1;
          if (idx_q == count_q) begin
            state_d = READY;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = REQ;
          end
        end
      end
      READY: begin
        if (commit) begin
          load_d  = 1'b1;
          state_d = IDLE;
          if (start) overrun_d = 1'b1;
        end else if (start) begin
          take_start = 1'b1;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_start) begin
      count_d = (sprite_count > MAX_CNT) ? MAX_CNT : sprite_count;
      idx_d   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      idx_q     <= 4'd0;
      overrun_q <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      load_q    <= load_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bg_addr_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) spr_addr_q[i] <= '0;
    end else if (take_start) begin
      bg_addr_q <= bg_addr;
      for (int i = 0; i < NUM_SPRITES; i++) spr_addr_q[i] <= sprite_addr[i];
    end
  end

  // Sprite slots are cleared on start so unfetched sprites stay transparent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NUM_SPRITES; i++) buf_q[i] <= '0;
    end else if (take_start) begin
      for (int i = 0; i < NUM_SPRITES; i++) buf_q[i] <= '0;
    end else if (capture) begin
      if (idx_q == 4'd0) buf_q[NUM_SPRITES] <= mem_rdata;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (idx_q == 4'(i + 1)) buf_q[i] <= mem_rdata;
      end
    end
  end

  always_comb begin
    cur_addr = bg_addr_q;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (idx_q == 4'(i + 1)) cur_addr = spr_addr_q[i];
    end
  end

  assign mem_rd          = (state_q == REQ);
  assign mem_addr        = mem_rd ? cur_addr : '0;
  assign busy            = (state_q == REQ) || (state_q == WAIT);
  assign ready           = (state_q == READY);
  assign load_sprite     = load_q;
  assign load_background = load_q;
  assign overrun         = overrun_q;

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_SPRITES; gi++) begin : g_load
      assign load_data[gi] = buf_q[gi];
    end
  endgenerate

endmodule

// File: doc/pattern_fetch.md
Name: pattern_fetch

Overview:
- Producer side of the sprite/background pixel shift-register block.
- During horizontal blank it reads one 32-bit pattern word (16 pixels × 2 bpp) for the background and for up to NUM_SPRITES sprites from pattern memory, one read at a time.
- Words are buffered internally. On a commit pulse, the fetcher presents all nine words on load_data and asserts load_sprite and load_background for one cycle.

Parameters:
- NUM_SPRITES, 8: sprite slots. Buffer index NUM_SPRITES is the background slot.
- ADDR_W, 16: pattern memory address width.
- DATA_W, 32: pattern word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a line fetch.
- commit  in  1  single-cycle pulse that transfers the buffer to the shift registers.
- sprite_count  in  4  number of active sprites this line, 0..NUM_SPRITES.
- sprite_addr  in  ADDR_W × NUM_SPRITES (unpacked [NUM_SPRITES-1:0])  per-slot pattern word address.
- bg_addr  in  ADDR_W  background pattern word address.
- mem_rd  out  1  read strobe, one cycle per read.
- mem_addr  out  ADDR_W  read address, valid when mem_rd=1.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  read data valid.
- load_data  out  DATA_W × (NUM_SPRITES+1) (unpacked [NUM_SPRITES:0])  buffered pattern words.
- load_sprite  out  1  one-cycle load strobe for all sprite shift registers.
- load_background  out  1  one-cycle load strobe for the background shift register.
- busy  out  1  fetch in progress.
- ready  out  1  buffer complete, awaiting commit.
- overrun  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - Outputs cleared: mem_rd, load_sprite, load_background, busy, ready, overrun all 0.
  - mem_addr=0; every load_data word is 0.
- Reset mid-fetch: the fetch is abandoned immediately. Any mem_rvalid arriving after reset is released is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT, READY.
  - busy=1 in REQ and WAIT. ready=1 in READY.
- IDLE or READY + start:
  - Latch sprite_count (values >NUM_SPRITES clamp to NUM_SPRITES), sprite_addr and bg_addr.
  - Zero every sprite slot of the buffer.
  - Set fetch index to the background slot.
  - Go to REQ. Starting from READY discards the previous buffer.
- REQ: assert mem_rd=1 for exactly one cycle with mem_addr = latched address of the current index, then go to WAIT. mem_rvalid is ignored in REQ.
- WAIT:
  - Hold mem_rd=0 until mem_rvalid=1. Wait time is unbounded; at most one read is outstanding.
  - On mem_rvalid, store mem_rdata into the current slot.
  - Index order: background first, then sprites 0..n-1 (n = latched count).
  - After the last word, go to READY; otherwise go to REQ with the next index.
  - n=0: only the background is read.
- Fetch timing with a 1-cycle memory (rvalid the cycle after mem_rd): 2 cycles per word. ready rises 2·(n+1) cycles after the start edge.
- Unfetched sprite slots stay 0 (transparent).
- load_data is driven from buffer registers and is stable except while words are being captured.
- READY + commit:
  - Assert load_sprite=1 and load_background=1 for exactly one cycle (the cycle after commit).
  - load_data holds the buffer during that cycle and afterwards, until the next start.
  - Go to IDLE.
- Commit and start in the same cycle in READY: commit is honoured, start is dropped, overrun is set.
- Protocol errors (set overrun=1; cleared only by reset):
  - start while busy: ignored.
  - commit in IDLE or while busy: ignored; no load strobes.

Test Plan:
- 1-cycle memory returning addr+0xA500_0000; start with sprite_count=3, bg_addr=0x0100, sprite_addr[0..2]=0x0200/0x0201/0x0202 -> mem_rd pulses at addresses 0x0100, 0x0200, 0x0201, 0x0202; ready rises 8 cycles after start; load_data[8]=0xA500_0100, [0..2]=0xA500_0200..0202, [3..7]=0.
- From the ready state, pulse commit -> load_sprite=load_background=1 for exactly one cycle; load_data unchanged; state returns to IDLE with busy=ready=0.
- sprite_count=0, then sprite_count=12 -> first run: a single background read, ready after 2 cycles. Second run: 9 reads (clamped to 8 sprites), ready after 18 cycles.
- mem_rvalid delayed 5 cycles per read with sprite_count=2 -> exactly 3 mem_rd pulses, each one cycle long; never two outstanding reads; ready only after the third rvalid.
- start during WAIT, then commit in IDLE -> both ignored; overrun=1 and stays 1; no extra mem_rd; no load strobes.
- Reset asserted while in WAIT, then a stray mem_rvalid after release -> all outputs 0 immediately on reset; the stray rvalid does not change load_data; a subsequent start works normally.
